axis_adc_decimator: RTL and testbench
=====================================

AXIS_ADC_DECIMATOR -- requirements
Module: axis_adc_decimator

Interface
REQ-001 Parameter S_AXIS_DATA_WIDTH, default 32: packed dual-channel ADC word, CH1 in [15:0], CH2 in [31:16].
REQ-002 Parameter ADC_WIDTH, default 14: significant two's-complement bits per lane, LSB-aligned, sign at bit ADC_WIDTH-1.
REQ-003 Parameter DECIM_LOG2, default 2: decimation factor N = 2^DECIM_LOG2, legal range 1..6.
REQ-004 Parameter M_AXIS_DATA_WIDTH, default 16: per-channel output width.
REQ-005 Port aclk, input, 1: the block's only clock; all logic on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Ports S_AXIS_tdata (input, S_AXIS_DATA_WIDTH) and S_AXIS_tvalid (input, 1): raw ADC stream; no tready, so the block never stalls its input.
REQ-008 Port decim_sync, input, 1: frame realignment strobe.
REQ-009 Ports M_AXIS_CH1_tdata and M_AXIS_CH2_tdata, output, M_AXIS_DATA_WIDTH each: decimated sums.
REQ-010 Ports M_AXIS_CH1_tvalid and M_AXIS_CH2_tvalid, output, 1 each: single-cycle valid pulses, driven identically.
REQ-011 Port dbg_count, output, DECIM_LOG2: current frame position.

Function
REQ-012 An input beat SHALL be accepted on every cycle where S_AXIS_tvalid=1; no other cycles advance state.
REQ-013 Each lane SHALL be sign-extended from ADC_WIDTH to ADC_WIDTH+DECIM_LOG2 bits (the accumulator width A) before summing.
REQ-014 The frame counter SHALL run 0..N-1 and wrap 0 after N-1; it increments only on accepted beats.
REQ-015 An accepted beat at count 0 SHALL load the accumulator with the sample; at counts 1..N-2 it SHALL add the sample.
REQ-016 An accepted beat at count N-1 SHALL register (accumulator + sample) to the output and pulse tvalid for exactly one cycle, on the following edge (latency 1).
REQ-017 The same beat SHALL clear the accumulator, so the next accepted beat starts a new frame with no gap cycle.
REQ-018 Output alignment: sum bit A-1 maps to output bit M_AXIS_DATA_WIDTH-1.
REQ-019 If A < M_AXIS_DATA_WIDTH, the output low bits SHALL be zero-filled; if A > M_AXIS_DATA_WIDTH, the low bits SHALL be truncated (arithmetic, no rounding).
REQ-020 tdata SHALL hold its value between pulses; tvalid SHALL be 0 on all other cycles.
REQ-021 decim_sync=1 together with an accepted beat: the partial frame SHALL be discarded, the accumulator loaded with that sample, count set to 1, and no output produced, even if count was N-1.
REQ-022 decim_sync=1 without an accepted beat: the accumulator SHALL be cleared and count set to 0.
REQ-023 Sums SHALL never overflow; A is sized for N full-scale samples.

Reset
REQ-024 While reset=1, the accumulators, count, both tdata outputs, both tvalid outputs and dbg_count SHALL all be 0, asynchronously.
REQ-025 Reset asserted mid-frame SHALL discard the partial sum; the first accepted beat after release SHALL be frame position 0.

Configuration
REQ-026 Macro ADC_DECIM_OFFSET_TRIM_EN defined: add input ports offset_ch1 and offset_ch2 (signed, M_AXIS_DATA_WIDTH each), registered each cycle.
REQ-027 With the macro defined, each offset SHALL be subtracted from its aligned sum, saturating to [-2^(M-1), 2^(M-1)-1]; output latency becomes 2 cycles and the tvalid pulse is delayed to match.
REQ-028 Macro undefined: the offset ports are absent and latency is 1.

Structure
REQ-029 Package axis_adc_decim_pkg SHALL hold the lane extraction offsets, the accumulator-width function A(ADC_WIDTH, DECIM_LOG2) and the saturation limits.
REQ-030 One sub-module, adc_decim_lane (one accumulator plus alignment and optional trim), SHALL be instantiated twice; the counter and sync logic stay in the top level.

Verification
REQ-031 Defaults; CH1=+8191 for 4 beats, tvalid continuous -> CH1 out 32764, one valid pulse 1 cycle after beat 4.
REQ-032 CH2=-8192 x4 with tvalid toggled 1,0,1,0,... -> out -32768 after the 4th accepted beat; count holds during gaps.
REQ-033 decim_sync with an accepted beat at count 3, CH1 samples 100 then 1 x3 -> no output at the sync beat; next output = 100+1+1+1 = 103.
REQ-034 Reset pulse after 2 beats of 1000 -> outputs 0; next 4 beats of 5 -> 20.
REQ-035 DECIM_LOG2=3, CH1=+8191 x8 -> A=17, out = 65528>>1 = 32764.
REQ-036 ADC_DECIM_OFFSET_TRIM_EN, offset_ch1=-100, sum 32764 -> 32767 saturated, latency 2.

Source files
------------

// File: rtl/axis_adc_decim_pkg.sv
// axis_adc_decim_pkg -- shared constants and helpers for the ADC decimator.
//   - CH1_LSB / CH2_LSB / LANE_WIDTH: where each ADC lane sits in the packed input word
//   - acc_width(): accumulator width A, wide enough for 2^decim_log2 full-scale samples
//   - sat_max() / sat_min(): signed limits of an m-bit output, used by the optional
//     offset trim (ADC_DECIM_OFFSET_TRIM_EN)
package axis_adc_decim_pkg;

  localparam int LANE_WIDTH = 16;
  localparam int CH1_LSB    = 0;
  localparam int CH2_LSB    = 16;

  function automatic int acc_width(input int adc_width, input int decim_log2);
    return adc_width + decim_log2;
  endfunction

  function automatic int sat_max(input int m);
    return (1 << (m - 1)) - 1;
  endfunction

  function automatic int sat_min(input int m);
    return -(1 << (m - 1));
  endfunction

endpackage

// File: rtl/axis_adc_decimator_if.sv
// axis_adc_decim_if -- one decimated output stream (data + single-cycle valid).
//   tdata  : W-bit decimated sum
//   tvalid : one-cycle pulse when tdata carries a new value
// Handshake: there is no tready; a beat is transferred on every cycle tvalid=1,
// and tdata holds its value on the cycles in between.
// Modports: master drives the stream, slave observes it.
interface axis_adc_decim_if #(
  parameter int W = 16
);
  logic [W-1:0] tdata;
  logic         tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input tdata, input tvalid);
endinterface

// File: rtl/adc_decim_lane.sv
// adc_decim_lane -- one channel of the decimator: sign extension, accumulator,
// output alignment and (with ADC_DECIM_OFFSET_TRIM_EN) saturating offset trim.
// Ports:
//   aclk, reset     : clock, asynchronous active-high reset
//   lane_data       : raw 16-bit lane, the low ADC_WIDTH bits are the sample
//   load/add/fin/clr: frame controls from the top-level counter (mutually exclusive)
//   offset          : signed trim value (only with ADC_DECIM_OFFSET_TRIM_EN)
//   m_axis          : decimated output stream
module adc_decim_lane
  import axis_adc_decim_pkg::*;
#(
  parameter int ADC_WIDTH  = 14,
  parameter int DECIM_LOG2 = 2,
  parameter int M          = 16
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic [LANE_WIDTH-1:0] lane_data,
  input  logic                  load,
  input  logic                  add,
  input  logic                  fin,
  input  logic                  clr,
`ifdef ADC_DECIM_OFFSET_TRIM_EN
  input  logic signed [M-1:0]   offset,
`endif
  axis_adc_decim_if.master      m_axis
);

  localparam int A = acc_width(ADC_WIDTH, DECIM_LOG2);

  logic signed [A-1:0] sample;
  logic signed [A-1:0] acc;
  logic signed [A-1:0] sum;
  logic        [M-1:0] aligned;

  // Upper lane bits above the ADC sample carry no information.
  wire unused_lane_bits = &{1'b0, lane_data[LANE_WIDTH-1:ADC_WIDTH]};

  assign sample = {{DECIM_LOG2{lane_data[ADC_WIDTH-1]}}, lane_data[ADC_WIDTH-1:0]};
  assign sum    = acc + sample;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr || fin) begin
      acc <= '0;
    end else if (load) begin
      acc <= sample;
    end else if (add) begin
      acc <= sum;
    end
  end

  // Sum MSB lands on output MSB: pad with zeros below, or drop LSBs.
  generate
    if (A > M) begin : g_trunc
      assign aligned = sum[A-1 -: M];
      wire unused_lsbs = &{1'b0, sum[A-M-1:0]};
    end else if (A == M) begin : g_exact
      assign aligned = sum;
    end else begin : g_pad
      assign aligned = {sum, {(M-A){1'b0}}};
    end
  endgenerate

`ifdef ADC_DECIM_OFFSET_TRIM_EN
  typedef logic signed [M:0] diff_t;
  localparam diff_t SAT_HI = diff_t'(sat_max(M));
  localparam diff_t SAT_LO = diff_t'(sat_min(M));

  logic signed [M-1:0] stage_q;
  logic                stage_v;
  logic signed [M-1:0] off_q;
  diff_t               diff;
  logic        [M-1:0] trimmed;

  // One extra bit so the subtraction itself cannot wrap before saturation.
  assign diff = {stage_q[M-1], stage_q} - {off_q[M-1], off_q};

  always_comb begin
    trimmed = diff[M-1:0];
    if (diff > SAT_HI) begin
      trimmed = SAT_HI[M-1:0];
    end else if (diff < SAT_LO) begin
      trimmed = SAT_LO[M-1:0];
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      stage_q       <= '0;
      stage_v       <= 1'b0;
      off_q         <= '0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
    end else begin
      off_q         <= offset;
      stage_v       <= fin;
      m_axis.tvalid <= stage_v;
      if (fin) begin
        stage_q <= aligned;
      end
      if (stage_v) begin
        m_axis.tdata <= trimmed;
      end
    end
  end
`else
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
    end else begin
      m_axis.tvalid <= fin;
      if (fin) begin
        m_axis.tdata <= aligned;
      end
    end
  end
`endif

endmodule

// File: rtl/axis_adc_decimator.sv
// axis_adc_decimator -- sums N = 2^DECIM_LOG2 consecutive accepted ADC beats per
// channel and emits one aligned sum per frame on each output stream.
// Ports:
//   aclk, reset                  : clock, asynchronous active-high reset
//   S_AXIS_tdata/S_AXIS_tvalid   : packed dual-lane ADC input, never stalled
//   decim_sync                   : frame realignment strobe
//   offset_ch1/offset_ch2        : signed trims (only with ADC_DECIM_OFFSET_TRIM_EN)
//   M_AXIS_CH{1,2}_tdata/_tvalid : decimated sums, valid pulses identical
//   dbg_count                    : current frame position
// Optional feature macro: ADC_DECIM_OFFSET_TRIM_EN (adds trim, latency 2 instead of 1).
module axis_adc_decimator
  import axis_adc_decim_pkg::*;
#(
  parameter int S_AXIS_DATA_WIDTH = 32,
  parameter int ADC_WIDTH         = 14,
  parameter int DECIM_LOG2        = 2,
  parameter int M_AXIS_DATA_WIDTH = 16
) (
  input  logic                                aclk,
  input  logic                                reset,
  input  logic [S_AXIS_DATA_WIDTH-1:0]        S_AXIS_tdata,
  input  logic                                S_AXIS_tvalid,
  input  logic                                decim_sync,
`ifdef ADC_DECIM_OFFSET_TRIM_EN
  input  logic signed [M_AXIS_DATA_WIDTH-1:0] offset_ch1,
  input  logic signed [M_AXIS_DATA_WIDTH-1:0] offset_ch2,
`endif
  output logic [M_AXIS_DATA_WIDTH-1:0]        M_AXIS_CH1_tdata,
  output logic                                M_AXIS_CH1_tvalid,
  output logic [M_AXIS_DATA_WIDTH-1:0]        M_AXIS_CH2_tdata,
  output logic                                M_AXIS_CH2_tvalid,
  output logic [DECIM_LOG2-1:0]               dbg_count
);

  localparam logic [DECIM_LOG2-1:0] LAST = '1;

  logic [DECIM_LOG2-1:0] count;
  logic                  beat;
  logic                  load, add, fin, clr;

  assign beat = S_AXIS_tvalid;

  // A sync beat restarts the frame with itself as sample 0, so it never finishes one.
  assign load = beat && (decim_sync || count == '0);
  assign add  = beat && !decim_sync && count != '0 && count != LAST;
  assign fin  = beat && !decim_sync && count == LAST;
  assign clr  = decim_sync && !beat;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (decim_sync) begin
      count <= beat ? DECIM_LOG2'(1) : '0;
    end else if (beat) begin
      count <= count + 1'b1;
    end
  end

  assign dbg_count = count;

  axis_adc_decim_if #(.W(M_AXIS_DATA_WIDTH)) ch1_if ();
  axis_adc_decim_if #(.W(M_AXIS_DATA_WIDTH)) ch2_if ();

  adc_decim_lane #(
    .ADC_WIDTH (ADC_WIDTH),
    .DECIM_LOG2(DECIM_LOG2),
    .M         (M_AXIS_DATA_WIDTH)
  ) u_lane_ch1 (
    .aclk     (aclk),
    .reset    (reset),
    .lane_data(S_AXIS_tdata[CH1_LSB +: LANE_WIDTH]),
    .load     (load),
    .add      (add),
    .fin      (fin),
    .clr      (clr),
`ifdef ADC_DECIM_OFFSET_TRIM_EN
    .offset   (offset_ch1),
`endif
    .m_axis   (ch1_if)
  );

  adc_decim_lane #(
    .ADC_WIDTH (ADC_WIDTH),
    .DECIM_LOG2(DECIM_LOG2),
    .M         (M_AXIS_DATA_WIDTH)
  ) u_lane_ch2 (
    .aclk     (aclk),
    .reset    (reset),
    .lane_data(S_AXIS_tdata[CH2_LSB +: LANE_WIDTH]),
    .load     (load),
    .add      (add),
    .fin      (fin),
    .clr      (clr),
`ifdef ADC_DECIM_OFFSET_TRIM_EN
    .offset   (offset_ch2),
`endif
    .m_axis   (ch2_if)
  );

  assign M_AXIS_CH1_tdata  = ch1_if.tdata;
  assign M_AXIS_CH1_tvalid = ch1_if.tvalid;
  assign M_AXIS_CH2_tdata  = ch2_if.tdata;
  assign M_AXIS_CH2_tvalid = ch2_if.tvalid;

endmodule

// File: tb/tb_axis_adc_decimator.sv
// tb_axis_adc_decimator -- directed bench for axis_adc_decimator.
// Main DUT uses default parameters; a second instance uses DECIM_LOG2=3.
// Expected sums are pushed as {cycle, ch2, ch1} into queues when the last beat
// of a frame is driven; monitors pop and compare whenever a valid appears.
module tb_axis_adc_decimator;

`ifdef ADC_DECIM_OFFSET_TRIM_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic aclk  = 1'b0;
  logic reset = 1'b1;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [31:0] s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        decim_sync = 1'b0;
  logic [15:0] ch1_tdata, ch2_tdata;
  logic        ch1_tvalid, ch2_tvalid;
  logic [1:0]  dbg_count;

  logic [31:0] s3_tdata  = '0;
  logic        s3_tvalid = 1'b0;
  logic        sync3     = 1'b0;
  logic [15:0] ch1_tdata3, ch2_tdata3;
  logic        ch1_tvalid3, ch2_tvalid3;
  logic [2:0]  dbg_count3;

`ifdef ADC_DECIM_OFFSET_TRIM_EN
  logic signed [15:0] offset_ch1 = '0;
  logic signed [15:0] offset_ch2 = '0;
  logic signed [15:0] zero_off   = '0;
`endif

  axis_adc_decimator dut (
    .aclk             (aclk),
    .reset            (reset),
    .S_AXIS_tdata     (s_tdata),
    .S_AXIS_tvalid    (s_tvalid),
    .decim_sync       (decim_sync),
`ifdef ADC_DECIM_OFFSET_TRIM_EN
    .offset_ch1       (offset_ch1),
    .offset_ch2       (offset_ch2),
`endif
    .M_AXIS_CH1_tdata (ch1_tdata),
    .M_AXIS_CH1_tvalid(ch1_tvalid),
    .M_AXIS_CH2_tdata (ch2_tdata),
    .M_AXIS_CH2_tvalid(ch2_tvalid),
    .dbg_count        (dbg_count)
  );

  axis_adc_decimator #(.DECIM_LOG2(3)) dut3 (
    .aclk             (aclk),
    .reset            (reset),
    .S_AXIS_tdata     (s3_tdata),
    .S_AXIS_tvalid    (s3_tvalid),
    .decim_sync       (sync3),
`ifdef ADC_DECIM_OFFSET_TRIM_EN
    .offset_ch1       (zero_off),
    .offset_ch2       (zero_off),
`endif
    .M_AXIS_CH1_tdata (ch1_tdata3),
    .M_AXIS_CH1_tvalid(ch1_tvalid3),
    .M_AXIS_CH2_tdata (ch2_tdata3),
    .M_AXIS_CH2_tvalid(ch2_tvalid3),
    .dbg_count        (dbg_count3)
  );

  // Observation views of the main DUT's output streams.
  axis_adc_decim_if #(.W(16)) ch1_view ();
  axis_adc_decim_if #(.W(16)) ch2_view ();
  assign ch1_view.tdata  = ch1_tdata;
  assign ch1_view.tvalid = ch1_tvalid;
  assign ch2_view.tdata  = ch2_tdata;
  assign ch2_view.tvalid = ch2_tvalid;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp3_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge aclk) begin
    logic [63:0] e;
    if (!reset && (ch1_view.tvalid || ch2_view.tvalid)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: valid at cycle %0d ch1=0x%0h ch2=0x%0h, expected none",
                 cyc, ch1_view.tdata, ch2_view.tdata);
      end else begin
        e = exp_q.pop_front();
        if ({cyc, ch2_view.tdata, ch1_view.tdata} !== e || ch1_view.tvalid !== ch2_view.tvalid) begin
          errors++;
          $display("FAIL out_sum: got cyc=%0d ch1=0x%0h ch2=0x%0h v=%b%b, expected cyc=%0d ch1=0x%0h ch2=0x%0h v=11",
                   cyc, ch1_view.tdata, ch2_view.tdata, ch1_view.tvalid, ch2_view.tvalid,
                   e[63:32], e[15:0], e[31:16]);
        end
      end
    end
  end

  always @(negedge aclk) begin
    logic [63:0] e;
    if (!reset && (ch1_tvalid3 || ch2_tvalid3)) begin
      checks++;
      if (exp3_q.size() == 0) begin
        errors++;
        $display("FAIL out3_unexpected: valid at cycle %0d ch1=0x%0h ch2=0x%0h, expected none",
                 cyc, ch1_tdata3, ch2_tdata3);
      end else begin
        e = exp3_q.pop_front();
        if ({cyc, ch2_tdata3, ch1_tdata3} !== e || ch1_tvalid3 !== ch2_tvalid3) begin
          errors++;
          $display("FAIL out3_sum: got cyc=%0d ch1=0x%0h ch2=0x%0h, expected cyc=%0d ch1=0x%0h ch2=0x%0h",
                   cyc, ch1_tdata3, ch2_tdata3, e[63:32], e[15:0], e[31:16]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic beat(input logic [15:0] c1, input logic [15:0] c2, input logic sync = 1'b0,
                      input logic push = 1'b0, input logic [15:0] e1 = '0, input logic [15:0] e2 = '0);
    @(negedge aclk);
    s_tdata    = {c2, c1};
    s_tvalid   = 1'b1;
    decim_sync = sync;
    if (push) exp_q.push_back({cyc + LAT, e2, e1});
  endtask

  task automatic idle(input logic sync = 1'b0);
    @(negedge aclk);
    s_tdata    = $urandom;
    s_tvalid   = 1'b0;
    decim_sync = sync;
  endtask

  task automatic beat3(input logic [15:0] c1, input logic [15:0] c2, input logic push = 1'b0,
                       input logic [15:0] e1 = '0, input logic [15:0] e2 = '0);
    @(negedge aclk);
    s3_tdata  = {c2, c1};
    s3_tvalid = 1'b1;
    if (push) exp3_q.push_back({cyc + LAT, e2, e1});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge aclk);
    check("rst_ch1", {16'h0, ch1_tdata}, 32'h0);
    check("rst_ch2", {16'h0, ch2_tdata}, 32'h0);
    check("rst_valid", {30'h0, ch1_tvalid, ch2_tvalid}, 32'h0);
    check("rst_count", {30'h0, dbg_count}, 32'h0);
    check("rst3_count", {29'h0, dbg_count3}, 32'h0);
    reset = 1'b0;

    // +8191 x4 on CH1 -> 32764
    repeat (3) beat(16'h1FFF, 16'h0000);
    beat(16'h1FFF, 16'h0000, 1'b0, 1'b1, 16'd32764, 16'h0000);
    idle();
    check("cnt_wrap", {30'h0, dbg_count}, 32'h0);

    // -8192 x4 on CH2 with gaps -> -32768
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) beat(16'h0000, 16'hE000, 1'b0, i == 6, 16'h0000, 16'h8000);
      else idle();
      if (i == 3) check("cnt_hold_gap", {30'h0, dbg_count}, 32'h2);
    end
    repeat (3) idle();
    check("hold_ch2", {16'h0, ch2_tdata}, 32'h8000);

    // sync with an accepted beat at count 3 -> restart with 100, then 1,1,1 -> 103
    repeat (3) beat(16'd50, 16'h0000);
    beat(16'd100, 16'h0000, 1'b1);
    check("cnt_pre_sync", {30'h0, dbg_count}, 32'h3);
    beat(16'd1, 16'h0000);
    check("cnt_after_sync", {30'h0, dbg_count}, 32'h1);
    beat(16'd1, 16'h0000);
    beat(16'd1, 16'h0000, 1'b0, 1'b1, 16'd103, 16'h0000);

    // sync without a beat clears the frame
    repeat (2) beat(16'd7, 16'h0000);
    idle(1'b1);
    idle();
    check("cnt_sync_idle", {30'h0, dbg_count}, 32'h0);
    repeat (3) beat(16'd2, 16'h0000);
    beat(16'd2, 16'h0000, 1'b0, 1'b1, 16'd8, 16'h0000);

    // sign taken from bit 13, upper lane bits ignored: CH1=-1 x4, CH2=+1 x4
    repeat (3) beat(16'h3FFF, 16'hC001);
    beat(16'h3FFF, 16'hC001, 1'b0, 1'b1, 16'hFFFC, 16'h0004);

    // back-to-back frames, no gap cycle
    for (int i = 1; i <= 8; i++) begin
      beat(16'(i), 16'(-i), 1'b0, (i == 4) || (i == 8),
           (i == 4) ? 16'd10 : 16'd26, (i == 4) ? 16'hFFF6 : 16'hFFE6);
    end
    idle();
    check("hold_ch1", {16'h0, ch1_tdata}, 32'd26);

    // asynchronous reset mid-frame
    repeat (2) beat(16'd1000, 16'h0000);
    @(negedge aclk);
    s_tvalid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_ch1", {16'h0, ch1_tdata}, 32'h0);
    check("rst_mid_count", {30'h0, dbg_count}, 32'h0);
    @(negedge aclk);
    reset = 1'b0;
    repeat (3) beat(16'd5, 16'h0000);
    beat(16'd5, 16'h0000, 1'b0, 1'b1, 16'd20, 16'h0000);

`ifdef ADC_DECIM_OFFSET_TRIM_EN
    // 32764 - (-100) saturates to 32767
    offset_ch1 = -16'sd100;
    repeat (3) beat(16'h1FFF, 16'h0000);
    beat(16'h1FFF, 16'h0000, 1'b0, 1'b1, 16'h7FFF, 16'h0000);
    repeat (3) idle();
    offset_ch1 = '0;
`endif
    idle();

    // DECIM_LOG2=3: A=17, +8191 x8 -> 32764, -8192 x8 -> -32768
    repeat (7) beat3(16'h1FFF, 16'hE000);
    beat3(16'h1FFF, 16'hE000, 1'b1, 16'd32764, 16'h8000);
    @(negedge aclk);
    s3_tvalid = 1'b0;

    // drain with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && exp3_q.size() == 0) break;
      @(negedge aclk);
    end
    repeat (2) @(negedge aclk);
    check("drain_main", exp_q.size(), 32'h0);
    check("drain_dut3", exp3_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
